// File: rtl/dcpu_dev_pkg.sv
// Shared definitions for the DCPU memory-mapped device slice: DMA FSM states,
// PS/2 frame length and the layout of the keyboard ring in RAM.
package dcpu_dev_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_RD_REQ,
        DMA_RD_WAIT,
        DMA_CHECK,
        DMA_WR_DATA,
        DMA_WR_IDX
    } dma_state_t;

    localparam int FRAME_BITS = 11;

    // Control words sit directly after the ring entries.
    localparam int WR_IDX_SLOT = 0;
    localparam int RD_IDX_SLOT = 1;

    function automatic logic [15:0] ring_slot_addr(input logic [15:0] base,
                                                   input int ring_log2,
                                                   input int slot);
        return base + 16'(1 << ring_log2) + 16'(slot);
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: line synchroniser, 11-bit frame shifter and inactivity timeout.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx
    import dcpu_dev_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic                  clk_prev;
    logic [FRAME_BITS-2:0] shreg;
    logic [3:0]            bit_cnt;
    logic [TW-1:0]         idle_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic                  fall;
    logic                  frame_ok;

    assign fall  = clk_prev & ~clk_sync[1];
    // frame[i] is bit i of the frame once the final (stop) bit arrives
    assign frame = {dat_sync[1], shreg};

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = ~frame[0] & frame[FRAME_BITS-1] & (^frame[9:1]);
`else
    logic unused_parity;
    assign unused_parity = frame[9];
    assign frame_ok = ~frame[0] & frame[FRAME_BITS-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_prev   <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            data_byte  <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_dat};
            clk_prev   <= clk_sync[1];
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        data_byte  <= frame[8:1];
                        byte_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg   <= frame[FRAME_BITS-1:1];
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is abandoned so the next start bit resyncs
                if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt   <= '0;
                    idle_cnt  <= '0;
                    frame_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_dma_keyboard.sv
// PS/2 keyboard that DMAs received scancodes into a RAM ring shared with the CPU.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_dma_keyboard
    import dcpu_dev_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = 16'h9000,
    parameter int          RING_LOG2      = 4,
    parameter int          TIMEOUT_CYCLES = 20000
) (
    input  logic        DMA_CLOCK,
    input  logic        RESET_N,
    inout  wire         PS2_CLK,
    inout  wire         PS2_DAT,
    output logic [15:0] DMA_addr,
    output logic [15:0] DMA_data,
    output logic        DMA_wren,
    input  logic [15:0] DMA_q,
    output logic [7:0]  LAST_CODE,
    output logic        OVERFLOW,
    output logic [7:0]  ERR_COUNT
);

    localparam logic [15:0] WR_IDX_ADDR = ring_slot_addr(BASE_ADDR, RING_LOG2, WR_IDX_SLOT);
    localparam logic [15:0] RD_IDX_ADDR = ring_slot_addr(BASE_ADDR, RING_LOG2, RD_IDX_SLOT);

    dma_state_t           state, next_state;
    logic [7:0]           rx_byte;
    logic                 rx_valid;
    logic                 rx_err;
    logic [7:0]           hold_byte;
    logic                 pending;
    logic [RING_LOG2-1:0] wr_idx;
    logic [RING_LOG2-1:0] next_idx;
    logic                 ring_full;
    logic [15:0]          nxt_addr;
    logic [15:0]          nxt_data;
    logic                 nxt_wren;
    logic                 unused_q;

    assign PS2_CLK = 1'bz;
    assign PS2_DAT = 1'bz;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (DMA_CLOCK),
        .rst_n      (RESET_N),
        .ps2_clk    (PS2_CLK),
        .ps2_dat    (PS2_DAT),
        .data_byte  (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_err)
    );

    assign next_idx  = wr_idx + RING_LOG2'(1);
    assign ring_full = (next_idx == DMA_q[RING_LOG2-1:0]);
    assign unused_q  = ^DMA_q[15:RING_LOG2];

    // Bus outputs are registered from next_state so they are glitch-free and
    // constant for the whole time the FSM sits in a state.
    always_comb begin
        next_state = state;
        nxt_addr   = 16'h0000;
        nxt_data   = 16'h0000;
        nxt_wren   = 1'b0;
        case (state)
            DMA_IDLE:    if (pending) next_state = DMA_RD_REQ;
            DMA_RD_REQ:  next_state = DMA_RD_WAIT;
            DMA_RD_WAIT: next_state = DMA_CHECK;
            DMA_CHECK:   next_state = ring_full ? DMA_IDLE : DMA_WR_DATA;
            DMA_WR_DATA: next_state = DMA_WR_IDX;
            DMA_WR_IDX:  next_state = DMA_IDLE;
            default:     next_state = DMA_IDLE;
        endcase
        case (next_state)
            DMA_RD_REQ, DMA_RD_WAIT, DMA_CHECK: nxt_addr = RD_IDX_ADDR;
            DMA_WR_DATA: begin
                nxt_addr = BASE_ADDR + 16'(wr_idx);
                nxt_data = {8'h00, hold_byte};
                nxt_wren = 1'b1;
            end
            DMA_WR_IDX: begin
                nxt_addr = WR_IDX_ADDR;
                nxt_data = 16'(next_idx);
                nxt_wren = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge DMA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= DMA_IDLE;
            DMA_addr <= 16'h0000;
            DMA_data <= 16'h0000;
            DMA_wren <= 1'b0;
        end else begin
            state    <= next_state;
            DMA_addr <= nxt_addr;
            DMA_data <= nxt_data;
            DMA_wren <= nxt_wren;
        end
    end

    // A byte arriving while one is still held is dropped; the receiver never stalls.
    always_ff @(posedge DMA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_byte <= 8'h00;
            pending   <= 1'b0;
            wr_idx    <= '0;
            LAST_CODE <= 8'h00;
            OVERFLOW  <= 1'b0;
            ERR_COUNT <= 8'h00;
        end else begin
            if (rx_valid) begin
                if (pending) begin
                    OVERFLOW <= 1'b1;
                end else begin
                    hold_byte <= rx_byte;
                    pending   <= 1'b1;
                end
            end
            if (state == DMA_CHECK && ring_full) begin
                pending  <= 1'b0;
                OVERFLOW <= 1'b1;
            end
            if (state == DMA_WR_IDX) begin
                wr_idx    <= next_idx;
                LAST_CODE <= hold_byte;
                pending   <= 1'b0;
            end
            if (rx_err && ERR_COUNT != 8'hFF)
                ERR_COUNT <= ERR_COUNT + 8'd1;
        end
    end

endmodule

// File: doc/ps2_dma_keyboard.md
PS2_DMA_KEYBOARD -- requirements
Module: ps2_dma_keyboard

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h9000, meaning the first RAM word of the keyboard ring.
REQ-002 SHALL have parameter RING_LOG2, default 4, meaning the ring holds 2^RING_LOG2 entries.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 20000, meaning the DMA_CLOCK cycles without a PS/2 falling edge before a partial frame is aborted.
REQ-004 SHALL have port DMA_CLOCK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports PS2_CLK and PS2_DAT, inout, 1 each, PS/2 device lines; receive-only, driven high-Z always.
REQ-007 SHALL have port DMA_addr, output, 16, RAM port-B address.
REQ-008 SHALL have port DMA_data, output, 16, RAM port-B write data.
REQ-009 SHALL have port DMA_wren, output, 1, RAM port-B write enable.
REQ-010 SHALL have port DMA_q, input, 16, RAM port-B read data, valid 2 cycles after DMA_addr is presented.
REQ-011 SHALL have port LAST_CODE, output, 8, the most recent accepted scancode.
REQ-012 SHALL have port OVERFLOW, output, 1, sticky flag: a byte was dropped.
REQ-013 SHALL have port ERR_COUNT, output, 8, saturating count of aborted or bad frames.

Function
REQ-014 SHALL use this RAM layout: BASE_ADDR+i for i in 0..2^RING_LOG2-1 is the ring; BASE_ADDR+2^RING_LOG2 is WR_IDX (device-owned); BASE_ADDR+2^RING_LOG2+1 is RD_IDX (CPU-owned).
REQ-015 SHALL synchronise PS2_CLK and PS2_DAT through 2 flip-flops and sample DAT on each synchronised CLK falling edge.
REQ-016 SHALL receive an 11-bit frame: start=0, 8 data bits LSB first, odd parity, stop=1.
REQ-017 SHALL discard a frame with start!=0 or stop!=1 and increment ERR_COUNT.
REQ-018 SHALL discard a partial frame after TIMEOUT_CYCLES with no falling edge, increment ERR_COUNT, and return to waiting for a start bit.
REQ-019 SHALL load a completed byte into a 1-entry holding register with a pending flag.
REQ-020 SHALL, if a byte completes while pending is set, drop the new byte and set OVERFLOW.
REQ-021 SHALL run DMA FSM states IDLE -> RD_REQ -> RD_WAIT -> CHECK -> WR_DATA -> WR_IDX -> IDLE.
REQ-022 SHALL leave IDLE only when pending is set.
REQ-023 SHALL, in RD_REQ, present BASE_ADDR+2^RING_LOG2+1 with wren=0.
REQ-024 SHALL, in RD_WAIT, hold for 1 cycle; CHECK SHALL sample DMA_q.
REQ-025 SHALL, in CHECK, compute next=(wr_idx+1) mod 2^RING_LOG2 and compare it with DMA_q[RING_LOG2-1:0].
REQ-026 SHALL, if next equals RD_IDX (ring full), clear pending, set OVERFLOW, leave LAST_CODE unchanged, and return to IDLE.
REQ-027 SHALL, in WR_DATA, write {8'h00, byte} to BASE_ADDR+wr_idx with wren=1 for exactly 1 cycle.
REQ-028 SHALL, in WR_IDX, write zero-extended next to the WR_IDX word, update internal wr_idx, update LAST_CODE, and clear pending.
REQ-029 SHALL hold DMA_wren=0 in all states except WR_DATA and WR_IDX, and hold DMA_addr stable within a state.
REQ-030 SHALL treat wr_idx wrap from 2^RING_LOG2-1 to 0 as normal.
REQ-031 SHALL saturate ERR_COUNT at 8'hFF.
REQ-032 SHALL allow the receiver to keep shifting while the DMA FSM is busy.

Reset
REQ-033 SHALL, on RESET_N low, asynchronously clear the receiver, FSM (to IDLE), wr_idx, pending, LAST_CODE=0, OVERFLOW=0, ERR_COUNT=0, DMA_addr=0, DMA_data=0, and DMA_wren=0.
REQ-034 SHALL, when reset occurs mid-frame or mid-DMA, abandon the operation without further RAM writes.
REQ-035 SHALL NOT clear RAM; on the first accepted byte after reset, WR_IDX in RAM is rewritten with 1.

Configuration
REQ-036 SHALL, with PS2_PARITY_CHECK_EN defined, discard frames failing odd parity and increment ERR_COUNT.
REQ-037 SHALL, without PS2_PARITY_CHECK_EN, ignore the parity bit entirely.

Structure
REQ-038 SHALL place the DMA FSM state enum, the frame-length constant (11), and the ring-layout offset constants in package dcpu_dev_pkg.
REQ-039 SHALL implement the synchroniser, frame shifter, and timeout in sub-module ps2_rx, which outputs byte, byte_valid, and frame_err.

Verification
REQ-040 SHALL test: frame for 0x1C, parity 0, RD_IDX=0 -> RAM[9000]=0x001C, RAM[9010]=0x0001, LAST_CODE=0x1C.
REQ-041 SHALL test: 15 bytes with RD_IDX=0, then a 16th byte -> the 16th is not written, OVERFLOW=1, WR_IDX=15.
REQ-042 SHALL test: WR_IDX=15 and RD_IDX=5, then byte 0x29 -> RAM[900F]=0x0029, WR_IDX=0.
REQ-043 SHALL test: a frame with wrong parity for 0x1C -> with PS2_PARITY_CHECK_EN, no write and ERR_COUNT=1; without it, RAM[9000]=0x001C.
REQ-044 SHALL test: PS2_CLK stopped after 5 bits for 20001 cycles, then a good frame for 0x5A -> ERR_COUNT=1, 0x5A stored.
REQ-045 SHALL test: RESET_N asserted during WR_DATA -> DMA_wren=0 in the same cycle, and all outputs at reset values.
